// File: rtl/regf_wb_if.sv
// Write-back request bus between NREQ requesters and the regf write arbiter.
// Requester i uses bit i of req_valid/req_ready and slices i*AW +: AW / i*DW +: DW.
interface regf_wb_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;

  // requester side
  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  // arbiter side
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regf_wb_arbiter.sv
// Register-file write-port arbiter with busy scoreboard.
// Round-robin grant among NREQ write-back requesters, registered regf write,
// 32-entry busy scoreboard with combinational hazard check for the issue stage.
// Optional macro REGF_WB_PRIO0_EN: requester 0 gets fixed highest priority and
// the remaining requesters round-robin over pointer range 1..NREQ-1.
module regf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  regf_wb_if.slave      req,
  output logic          w_enable_o,
  output logic [AW-1:0] w_addr_o,
  output logic [DW-1:0] w_data_o,
  input  logic          issue_valid_i,
  input  logic [AW-1:0] issue_rd_i,
  input  logic [AW-1:0] chk_rs1_i,
  input  logic [AW-1:0] chk_rs2_i,
  input  logic [AW-1:0] chk_rd_i,
  output logic          hazard_o,
  output logic [31:0]   busy_mask_o
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            init_q;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            w_en_q, w_en_d;
  logic [AW-1:0]   w_addr_q, w_addr_d;
  logic [DW-1:0]   w_data_q, w_data_d;
  logic [31:0]     busy_q, busy_d;

  // Hold grants off for one settle cycle after reset so requesters that kept
  // valid asserted through reset are not granted in the release cycle.
  always_ff @(posedge clk) begin
    if (rst) init_q <= 1'b1;
    else     init_q <= 1'b0;
  end

  // Grant search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    int base;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    base    = 0;
    if (!(rst || init_q)) begin
`ifdef REGF_WB_PRIO0_EN
      if (req.req_valid[0]) begin
        grant[0] = 1'b1;
        gnt_any  = 1'b1;
      end else begin
        // pointer value 0 (reset) behaves as 1 in the 1..NREQ-1 ring
        base = (ptr_q == '0) ? 1 : int'(ptr_q);
        for (int k = 0; k < NREQ-1; k++) begin
          idx = base + k;
          if (idx >= NREQ) idx = idx - (NREQ-1);
          if (!gnt_any && req.req_valid[idx]) begin
            grant[idx] = 1'b1;
            gnt_idx    = PW'(idx);
            gnt_any    = 1'b1;
          end
        end
      end
`else
      base = int'(ptr_q);
      for (int k = 0; k < NREQ; k++) begin
        idx = base + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_any && req.req_valid[idx]) begin
          grant[idx] = 1'b1;
          gnt_idx    = PW'(idx);
          gnt_any    = 1'b1;
        end
      end
`endif
    end
  end

  assign req.req_ready = grant;
  assign sel_addr = req.req_addr[int'(gnt_idx)*AW +: AW];
  assign sel_data = req.req_data[int'(gnt_idx)*DW +: DW];

  // Pointer advance: move past the winner; hold when nothing was granted.
  always_comb begin
    ptr_d = ptr_q;
`ifdef REGF_WB_PRIO0_EN
    if (gnt_any && gnt_idx != '0)
      ptr_d = (gnt_idx == PW'(NREQ-1)) ? PW'(1) : gnt_idx + PW'(1);
`else
    if (gnt_any)
      ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
`endif
  end

  // Write path next-state: x0 writes are consumed but never reach regf.
  always_comb begin
    w_en_d   = gnt_any && (sel_addr != '0);
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (w_en_d) begin
      w_addr_d = sel_addr;
      w_data_d = sel_data;
    end
  end

  // Scoreboard next-state: clear on commit, then set on issue so a new
  // producer issued on the commit edge keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (w_en_q) busy_d[w_addr_q] = 1'b0;
    if (issue_valid_i && issue_rd_i != '0) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      busy_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      busy_q   <= busy_d;
    end
  end

  assign w_enable_o  = w_en_q;
  assign w_addr_o    = w_addr_q;
  assign w_data_o    = w_data_q;
  assign busy_mask_o = busy_q;
  assign hazard_o    = busy_q[chk_rs1_i] | busy_q[chk_rs2_i] | busy_q[chk_rd_i];

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Bench for regf_wb_arbiter: table-driven grant/write-path vectors plus
// directed scoreboard, same-edge and x0 sequences. Includes a small regf model
// with registered reads to check read-after-commit data.
module tb_regf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_enable;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          issue_valid;
  logic [AW-1:0] issue_rd, chk_rs1, chk_rs2, chk_rd;
  logic          hazard;
  logic [31:0]   busy_mask;

  int checks = 0;
  int errors = 0;

  regf_wb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(bus),
    .w_enable_o(w_enable), .w_addr_o(w_addr), .w_data_o(w_data),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .chk_rs1_i(chk_rs1), .chk_rs2_i(chk_rs2), .chk_rd_i(chk_rd),
    .hazard_o(hazard), .busy_mask_o(busy_mask)
  );

  always #5 clk = ~clk;

  // regf model: write on w_enable, registered read returns old value on a write edge
  logic [DW-1:0] rf [32];
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (w_enable) rf[w_addr] <= w_data;
    rd_q <= rf[rd_addr];
  end

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  rdy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;
  vec_t tbl[12];
  int   ntbl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1;
    bus.req_valid = 3'b111;
    set_req(0, 5'd1, 32'hA0);
    set_req(1, 5'd2, 32'hA1);
    set_req(2, 5'd3, 32'hA2);
    issue_valid = 1'b0; issue_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0; rd_addr = '0;

`ifdef REGF_WB_PRIO0_EN
    ntbl = 8;
    tbl[0] = '{3'b111, 3'b001, 1'b0, 5'd0, 32'h0};
    tbl[1] = '{3'b111, 3'b001, 1'b1, 5'd1, 32'hA0};
    tbl[2] = '{3'b111, 3'b001, 1'b1, 5'd1, 32'hA0};
    tbl[3] = '{3'b111, 3'b001, 1'b1, 5'd1, 32'hA0};
    tbl[4] = '{3'b110, 3'b010, 1'b1, 5'd1, 32'hA0};
    tbl[5] = '{3'b110, 3'b100, 1'b1, 5'd2, 32'hA1};
    tbl[6] = '{3'b110, 3'b010, 1'b1, 5'd3, 32'hA2};
    tbl[7] = '{3'b000, 3'b000, 1'b1, 5'd2, 32'hA1};
`else
    ntbl = 12;
    tbl[0]  = '{3'b111, 3'b001, 1'b0, 5'd0, 32'h0};
    tbl[1]  = '{3'b111, 3'b010, 1'b1, 5'd1, 32'hA0};
    tbl[2]  = '{3'b111, 3'b100, 1'b1, 5'd2, 32'hA1};
    tbl[3]  = '{3'b111, 3'b001, 1'b1, 5'd3, 32'hA2};
    tbl[4]  = '{3'b111, 3'b010, 1'b1, 5'd1, 32'hA0};
    tbl[5]  = '{3'b111, 3'b100, 1'b1, 5'd2, 32'hA1};
    tbl[6]  = '{3'b000, 3'b000, 1'b1, 5'd3, 32'hA2};
    tbl[7]  = '{3'b000, 3'b000, 1'b0, 5'd3, 32'hA2};
    tbl[8]  = '{3'b110, 3'b010, 1'b0, 5'd3, 32'hA2};
    tbl[9]  = '{3'b110, 3'b100, 1'b1, 5'd2, 32'hA1};
    tbl[10] = '{3'b011, 3'b001, 1'b1, 5'd3, 32'hA2};
    tbl[11] = '{3'b000, 3'b000, 1'b1, 5'd1, 32'hA0};
`endif

    // reset held with all requesters valid, then one release cycle
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_wen",   64'(w_enable),      64'd0);
      chk("rst_busy",  64'(busy_mask),     64'd0);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("post_rst_wen",   64'(w_enable),      64'd0);
    chk("post_rst_busy",  64'(busy_mask),     64'd0);
    next_cycle();

    // grant order and write path
    for (int i = 0; i < ntbl; i++) begin
      bus.req_valid = tbl[i].valid;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_wen", i),   64'(w_enable),      64'(tbl[i].wen));
      chk($sformatf("tbl%0d_waddr", i), 64'(w_addr),        64'(tbl[i].waddr));
      chk($sformatf("tbl%0d_wdata", i), 64'(w_data),        64'(tbl[i].wdata));
      next_cycle();
    end
    bus.req_valid = 3'b000;

    // scoreboard timing: issue x5, requester 1 writes x5 three cycles later
    issue_valid = 1'b1; issue_rd = 5'd5; chk_rs1 = 5'd5;
    @(negedge clk);
    chk("sb_issue_cycle_hazard", 64'(hazard), 64'd0);
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("sb_busy5", 64'(busy_mask), 64'h20);
    chk("sb_hazard_rs1", 64'(hazard), 64'd1);
    next_cycle();
    chk_rs1 = 5'd0; chk_rs2 = 5'd5;
    @(negedge clk);
    chk("sb_hazard_rs2", 64'(hazard), 64'd1);
    next_cycle();
    chk_rs2 = 5'd0; chk_rd = 5'd5;
    bus.req_valid = 3'b010; set_req(1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("sb_wr_ready", 64'(bus.req_ready), 64'b010);
    chk("sb_hazard_rd", 64'(hazard), 64'd1);
    next_cycle();
    bus.req_valid = 3'b000; chk_rd = 5'd0; chk_rs1 = 5'd5;
    @(negedge clk);
    chk("sb_wen", 64'(w_enable), 64'd1);
    chk("sb_waddr", 64'(w_addr), 64'd5);
    chk("sb_wdata", 64'(w_data), 64'hDEADBEEF);
    chk("sb_hazard_commit_cycle", 64'(hazard), 64'd1);
    next_cycle();
    rd_addr = 5'd5;
    @(negedge clk);
    chk("sb_hazard_after_commit", 64'(hazard), 64'd0);
    chk("sb_busy_clear", 64'(busy_mask), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("sb_regf_read", 64'(rd_q), 64'hDEADBEEF);
    next_cycle();
    chk_rs1 = 5'd0;

    // same-edge set and clear of x7
    issue_valid = 1'b1; issue_rd = 5'd7;
    next_cycle();
    issue_valid = 1'b0;
    bus.req_valid = 3'b100; set_req(2, 5'd7, 32'h77);
    @(negedge clk);
    chk("se_ready", 64'(bus.req_ready), 64'b100);
    chk("se_busy_set", 64'(busy_mask), 64'h80);
    next_cycle();
    bus.req_valid = 3'b000;
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    chk("se_wen", 64'(w_enable), 64'd1);
    chk("se_waddr", 64'(w_addr), 64'd7);
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("se_set_wins", 64'(busy_mask), 64'h80);
    next_cycle();
    bus.req_valid = 3'b100; set_req(2, 5'd7, 32'h78);
    next_cycle();
    bus.req_valid = 3'b000;
    @(negedge clk);
    chk("se_second_wen", 64'(w_enable), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("se_second_clear", 64'(busy_mask), 64'd0);
    next_cycle();

    // x0: handshake consumed, no regf write, no busy bit
    bus.req_valid = 3'b001; set_req(0, 5'd0, 32'h55);
    issue_valid = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    chk("x0_ready", 64'(bus.req_ready), 64'b001);
    next_cycle();
    bus.req_valid = 3'b000; issue_valid = 1'b0;
    @(negedge clk);
    chk("x0_wen", 64'(w_enable), 64'd0);
    chk("x0_waddr_hold", 64'(w_addr), 64'd7);
    chk("x0_wdata_hold", 64'(w_data), 64'h78);
    chk("x0_busy", 64'(busy_mask), 64'd0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
